// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: opcodes, FSM states, bus widths.
package seq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDO = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_LDM = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    FETCH1,
    FETCH2,
    EXEC,
    MEM,
    HALT
  } state_t;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure combinational opcode classifier used by the sequencer FSM.
module instr_decode
  import seq_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       is_two_byte,
  output logic       is_exec,
  output logic       is_halt
);

  always_comb begin
    is_two_byte = 1'b0;
    is_exec     = 1'b0;
    is_halt     = 1'b0;
    case (opcode)
      OP_LDO, OP_LDA, OP_STO: is_two_byte = 1'b1;
      OP_PRE, OP_ADD, OP_LDM: is_exec     = 1'b1;
      OP_HLT:                 is_halt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_seq.sv
// Fetch/execute sequencer for an 8-bit accumulator-style CPU.
// Optional feature macro: SEQ_RESUME_EN adds a resume input that leaves HALT.
module instr_seq
  import seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SEQ_RESUME_EN
  input  logic              resume,
`endif
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ena,
  output logic              ram_read,
  output logic              ram_write,
  output logic [2:0]        opcode,
  output logic [4:0]        reg_sel,
  output logic              exec_en,
  output logic              load_en,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   operand;
  logic [ADDR_W-1:0]   pc_reg;

  logic fetch_two_byte, fetch_exec, fetch_halt;
  logic ir_two_byte, ir_exec, ir_halt;

  // The fetch-side decoder only steers the next state; strobes use the IR decoder.
  instr_decode u_dec_fetch (
    .opcode      (rom_data[7:5]),
    .is_two_byte (fetch_two_byte),
    .is_exec     (fetch_exec),
    .is_halt     (fetch_halt)
  );

  instr_decode u_dec_ir (
    .opcode      (ir[7:5]),
    .is_two_byte (ir_two_byte),
    .is_exec     (ir_exec),
    .is_halt     (ir_halt)
  );

  logic unused_decode;
  assign unused_decode = &{1'b0, fetch_exec, fetch_halt, ir_two_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH1;
      pc_reg  <= PC_RESET;
      ir      <= '0;
      operand <= '0;
    end else begin
      case (state)
        FETCH1: begin
          ir     <= rom_data;
          pc_reg <= pc_inc(pc_reg);
          state  <= fetch_two_byte ? FETCH2 : EXEC;
        end
        FETCH2: begin
          operand <= rom_data;
          pc_reg  <= pc_inc(pc_reg);
          state   <= MEM;
        end
        MEM:  state <= FETCH1;
        EXEC: state <= ir_halt ? HALT : FETCH1;
        HALT: begin
`ifdef SEQ_RESUME_EN
          if (resume) state <= FETCH1;
`endif
        end
        default: state <= FETCH1;
      endcase
    end
  end

  // Strobes come from registered state/IR only; rst gates them off while asserted.
  always_comb begin
    rom_addr  = pc_reg;
    rom_read  = 1'b0;
    ram_ena   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    exec_en   = 1'b0;
    load_en   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH1, FETCH2: rom_read = 1'b1;
        MEM: begin
          case (ir[7:5])
            OP_LDO: begin
              rom_addr = operand;
              rom_read = 1'b1;
              load_en  = 1'b1;
            end
            OP_LDA: begin
              ram_ena  = 1'b1;
              ram_read = 1'b1;
              load_en  = 1'b1;
            end
            OP_STO: begin
              ram_ena   = 1'b1;
              ram_write = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC:    exec_en = ir_exec;
        default: ;
      endcase
    end
  end

  assign rom_ena  = rom_read;
  assign ram_addr = operand;
  assign opcode   = ir[7:5];
  assign reg_sel  = ir[4:0];
  assign halted   = (state == HALT);
  assign pc       = pc_reg;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: main program from PC 0 plus a second instance reset to 8'hFF.
`timescale 1ns/1ps
module tb_instr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [7:0] rom [256];

  logic [7:0] m_rom_data, m_rom_addr, m_ram_addr, m_pc;
  logic       m_rom_read, m_rom_ena, m_ram_ena, m_ram_read, m_ram_write;
  logic       m_exec_en, m_load_en, m_halted;
  logic [2:0] m_opcode;
  logic [4:0] m_reg_sel;

  logic [7:0] w_rom_data, w_rom_addr, w_ram_addr, w_pc;
  logic       w_rom_read, w_rom_ena, w_ram_ena, w_ram_read, w_ram_write;
  logic       w_exec_en, w_load_en, w_halted;
  logic [2:0] w_opcode;
  logic [4:0] w_reg_sel;

`ifdef SEQ_RESUME_EN
  logic resume = 1'b0;
  logic resume2 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_rom_data = rom[m_rom_addr];
  assign w_rom_data = rom[w_rom_addr];

  instr_seq #(.PC_RESET(8'h00)) u_dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_RESUME_EN
    .resume(resume),
`endif
    .rom_data(m_rom_data), .rom_addr(m_rom_addr), .rom_read(m_rom_read), .rom_ena(m_rom_ena),
    .ram_addr(m_ram_addr), .ram_ena(m_ram_ena), .ram_read(m_ram_read), .ram_write(m_ram_write),
    .opcode(m_opcode), .reg_sel(m_reg_sel), .exec_en(m_exec_en), .load_en(m_load_en),
    .halted(m_halted), .pc(m_pc)
  );

  instr_seq #(.PC_RESET(8'hFF)) u_wrap (
    .clk(clk), .rst(rst2),
`ifdef SEQ_RESUME_EN
    .resume(resume2),
`endif
    .rom_data(w_rom_data), .rom_addr(w_rom_addr), .rom_read(w_rom_read), .rom_ena(w_rom_ena),
    .ram_addr(w_ram_addr), .ram_ena(w_ram_ena), .ram_read(w_ram_read), .ram_write(w_ram_write),
    .opcode(w_opcode), .reg_sel(w_reg_sel), .exec_en(w_exec_en), .load_en(w_load_en),
    .halted(w_halted), .pc(w_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed main-DUT strobe vector: {rom_read, rom_ena, ram_ena, ram_read, ram_write, exec_en, load_en}
  function automatic logic [6:0] m_strobes();
    return {m_rom_read, m_rom_ena, m_ram_ena, m_ram_read, m_ram_write, m_exec_en, m_load_en};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[1]  = 8'h21; rom[2] = 8'h41; rom[65] = 8'h25;
    rom[3]  = 8'h61; rom[4] = 8'h01;
    rom[5]  = 8'h42; rom[6] = 8'h01;
    rom[7]  = 8'h81; rom[8] = 8'hA2; rom[9] = 8'hC1;
    rom[19] = 8'hE0;
    rom[255] = 8'h23;

    repeat (3) @(negedge clk);
    chk("reset_strobes", m_strobes(), 7'b0000000);
    chk("reset_pc", m_pc, 8'h00);
    chk("reset_halted", m_halted, 1'b0);
    chk("reset_ir", {m_opcode, m_reg_sel}, 8'h00);

    rst = 1'b0; #1;
    chk("f1_nop_strobes", m_strobes(), 7'b1100000);
    chk("f1_nop_addr", m_rom_addr, 8'h00);

    @(negedge clk);
    chk("exec_nop_strobes", m_strobes(), 7'b0000000);
    chk("exec_nop_pc", m_pc, 8'h01);
    @(negedge clk);
    chk("f1_ldo_addr", m_rom_addr, 8'h01);
    @(negedge clk);
    chk("f2_ldo_addr", m_rom_addr, 8'h02);
    chk("f2_ldo_ir", {m_opcode, m_reg_sel}, 8'h21);
    @(negedge clk);
    chk("mem_ldo_strobes", m_strobes(), 7'b1100001);
    chk("mem_ldo_addr", m_rom_addr, 8'd65);
    chk("mem_ldo_data", m_rom_data, 8'd37);
    chk("mem_ldo_regsel", m_reg_sel, 5'd1);
    chk("mem_ldo_pc", m_pc, 8'h03);

    repeat (3) @(negedge clk);
    chk("mem_sto_strobes", m_strobes(), 7'b0010100);
    chk("mem_sto_addr", m_ram_addr, 8'h01);
    chk("mem_sto_pc", m_pc, 8'h05);
    @(negedge clk);
    chk("after_sto_strobes", m_strobes(), 7'b1100000);

    repeat (2) @(negedge clk);
    chk("mem_lda_strobes", m_strobes(), 7'b0011001);
    chk("mem_lda_regsel", m_reg_sel, 5'd2);
    chk("mem_lda_addr", m_ram_addr, 8'h01);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("alu_f1_strobes", m_strobes(), 7'b1100000);
      @(negedge clk);
      chk("alu_exec_strobes", m_strobes(), 7'b0000010);
      chk("alu_exec_opcode", m_opcode, 3'd4 + 3'(k));
      chk("alu_exec_pc", m_pc, 8'd8 + 8'(k));
    end

    repeat (18) @(negedge clk);
    @(negedge clk);
    chk("f1_hlt_addr", m_rom_addr, 8'd19);
    @(negedge clk);
    chk("exec_hlt_strobes", m_strobes(), 7'b0000000);
    chk("exec_hlt_opcode", m_opcode, 3'd7);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("halt_flag", m_halted, 1'b1);
      chk("halt_pc", m_pc, 8'd20);
      chk("halt_strobes", m_strobes(), 7'b0000000);
    end

`ifdef SEQ_RESUME_EN
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_halted", m_halted, 1'b0);
    chk("resume_addr", m_rom_addr, 8'd20);
    chk("resume_strobes", m_strobes(), 7'b1100000);
`endif

    rst2 = 1'b0; #1;
    chk("wrap_f1_addr", w_rom_addr, 8'hFF);
    chk("wrap_f1_read", w_rom_read, 1'b1);
    @(negedge clk);
    chk("wrap_f2_pc", w_pc, 8'h00);
    chk("wrap_f2_addr", w_rom_addr, 8'h00);
    chk("wrap_f2_ir", {w_opcode, w_reg_sel}, 8'h23);
    @(negedge clk);
    chk("wrap_mem_addr", w_rom_addr, 8'h00);
    chk("wrap_mem_load", w_load_en, 1'b1);
    chk("wrap_mem_pc", w_pc, 8'h01);

    repeat (6) @(negedge clk);
    chk("abort_sto_write", w_ram_write, 1'b1);
    chk("abort_sto_pc", w_pc, 8'h05);
    rst2 = 1'b1; #1;
    chk("abort_write_gone", {w_ram_ena, w_ram_write}, 2'b00);
    chk("abort_pc", w_pc, 8'hFF);
    @(negedge clk);
    chk("abort_still_idle", {w_rom_read, w_ram_ena, w_ram_write, w_load_en}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
